rriot_timer_sched: RTL

- Scheduler that shares the single RRIOT interval timer among NREQ hardware requesters.
- Each requester asks for an interval (prescale select plus count).
- The block arbitrates round-robin, programs the timer through its register port, waits for the timer's active-low irq, acknowledges it, and returns a per-requester done pulse.
- Sits between the requester logic and the timer's A/DI/DO/we_n/irq pins, in place of the CPU bus path.

---
 rtl/rriot_pkg.sv | 34 +++
 rtl/rriot_timer_sched_rr_arbiter.sv | 31 +++
 rtl/rriot_timer_sched.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/rriot_pkg.sv
// Shared types and constants for the RRIOT interval timer and its request scheduler.
package rriot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PROG,
    ARM,
    WAIT,
    ACK,
    CLR,
    KILL
  } tsched_state_t;

  // Prescale select as decoded by the timer: clocks per tick.
  typedef enum logic [1:0] {
    DIV_1    = 2'd0,
    DIV_8    = 2'd1,
    DIV_64   = 2'd2,
    DIV_1024 = 2'd3
  } rriot_div_t;

  // Status read: touches neither the count nor the irq enable.
  localparam logic [2:0] TMR_A_STATUS = 3'b101;
  // Count read with irq enable kept: clears a pending timer irq.
  localparam logic [2:0] TMR_A_READ   = 3'b100;
  // Write with irq disabled, used to abandon an interval.
  localparam logic [2:0] TMR_A_KILL   = 3'b000;

  // A zero tick count is served as a single tick.
  function automatic logic [7:0] tick_count(input logic [7:0] c);
    return (c == 8'd0) ? 8'd1 : c;
  endfunction

endpackage

// File: rtl/rriot_timer_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first request at or above ptr, wrapping to 0.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            vld
);

  // Scan NREQ positions starting at ptr; the first set request wins.
  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    j   = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!vld && req[j]) begin
        vld    = 1'b1;
        idx    = IDW'(j);
        gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rriot_timer_sched.sv
// Shares one RRIOT interval timer between NREQ requesters: round-robin grant,
// program the timer, wait for its irq, acknowledge it, pulse done to the owner.
// Optional: define TSCHED_CANCEL_EN for cancel/cancelled ports and the KILL state.
module rriot_timer_sched
  import rriot_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [2*NREQ-1:0] req_div,
  input  logic [8*NREQ-1:0] req_count,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [IDW-1:0]    owner,
  output logic              tmr_we_n,
  output logic [2:0]        tmr_a,
  output logic [7:0]        tmr_di,
  input  logic [7:0]        tmr_do,
  input  logic              tmr_irq_n
`ifdef TSCHED_CANCEL_EN
  ,
  input  logic [NREQ-1:0]   cancel,
  output logic [NREQ-1:0]   cancelled
`endif
);

  tsched_state_t   state, state_nxt;
  logic            phase, phase_nxt;
  logic [IDW-1:0]  rr_ptr, rr_ptr_nxt, owner_nxt;
  logic [NREQ-1:0] req_ready_nxt, done_nxt;
  logic            busy_nxt, we_n_nxt;
  logic [2:0]      a_nxt;
  logic [7:0]      di_nxt;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gidx;
  logic            gvld;
  rriot_div_t      gdiv;
  logic [7:0]      gcount;

  // The timer count readback is not needed to sequence intervals.
  logic tmr_do_unused;
  assign tmr_do_unused = ^tmr_do;

`ifdef TSCHED_CANCEL_EN
  logic            killed, killed_nxt;
  logic [NREQ-1:0] cancelled_nxt;
`endif

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gidx),
    .vld (gvld)
  );

  assign gdiv   = rriot_div_t'(req_div[2*gidx +: 2]);
  assign gcount = req_count[8*gidx +: 8];

  // Next state plus next value of every registered output; timer drive is
  // computed on the transition so it is on the pins during the target state.
  always_comb begin
    state_nxt     = state;
    phase_nxt     = phase;
    rr_ptr_nxt    = rr_ptr;
    owner_nxt     = owner;
    req_ready_nxt = '0;
    done_nxt      = '0;
    we_n_nxt      = 1'b1;
    a_nxt         = TMR_A_STATUS;
    di_nxt        = 8'd0;
`ifdef TSCHED_CANCEL_EN
    killed_nxt    = killed;
    cancelled_nxt = '0;
`endif
    case (state)
      IDLE: begin
        // busy is still high in the done cycle, which forces one idle gap.
        if (gvld && !busy) begin
          req_ready_nxt = gnt;
          owner_nxt     = gidx;
          rr_ptr_nxt    = (gidx == IDW'(NREQ - 1)) ? '0 : gidx + IDW'(1);
          state_nxt     = PROG;
          we_n_nxt      = 1'b0;
          a_nxt         = {1'b1, gdiv};
          di_nxt        = tick_count(gcount);
        end
      end
      PROG: begin
        state_nxt = ARM;
        phase_nxt = 1'b0;
      end
      ARM: begin
        // irq may still show a stale assertion until the timer re-registers it.
        if (phase) state_nxt = WAIT;
        else       phase_nxt = 1'b1;
      end
      WAIT: begin
        if (!tmr_irq_n) begin
          state_nxt = ACK;
          a_nxt     = TMR_A_READ;
        end
      end
      ACK: begin
        state_nxt = CLR;
        phase_nxt = 1'b0;
      end
      CLR: begin
        if (phase && tmr_irq_n) begin
          state_nxt = IDLE;
`ifdef TSCHED_CANCEL_EN
          killed_nxt = 1'b0;
          if (killed) cancelled_nxt[owner] = 1'b1;
          else        done_nxt[owner]      = 1'b1;
`else
          done_nxt[owner] = 1'b1;
`endif
        end else begin
          phase_nxt = 1'b1;
        end
      end
`ifdef TSCHED_CANCEL_EN
      KILL: begin
        state_nxt = CLR;
        phase_nxt = 1'b0;
      end
`endif
      default: state_nxt = IDLE;
    endcase
`ifdef TSCHED_CANCEL_EN
    // Owner cancel while armed or waiting: rewrite the timer with irq disabled.
    if ((state == ARM || state == WAIT) && cancel[owner]) begin
      state_nxt  = KILL;
      killed_nxt = 1'b1;
      we_n_nxt   = 1'b0;
      a_nxt      = TMR_A_KILL;
      di_nxt     = 8'd1;
    end
    busy_nxt = (state_nxt != IDLE) || (|done_nxt) || (|cancelled_nxt);
`else
    busy_nxt = (state_nxt != IDLE) || (|done_nxt);
`endif
  end

  // State, pointer and all outputs registered; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      phase     <= 1'b0;
      rr_ptr    <= '0;
      owner     <= '0;
      req_ready <= '0;
      done      <= '0;
      busy      <= 1'b0;
      tmr_we_n  <= 1'b1;
      tmr_a     <= TMR_A_STATUS;
      tmr_di    <= 8'd0;
`ifdef TSCHED_CANCEL_EN
      killed    <= 1'b0;
      cancelled <= '0;
`endif
    end else begin
      state     <= state_nxt;
      phase     <= phase_nxt;
      rr_ptr    <= rr_ptr_nxt;
      owner     <= owner_nxt;
      req_ready <= req_ready_nxt;
      done      <= done_nxt;
      busy      <= busy_nxt;
      tmr_we_n  <= we_n_nxt;
      tmr_a     <= a_nxt;
      tmr_di    <= di_nxt;
`ifdef TSCHED_CANCEL_EN
      killed    <= killed_nxt;
      cancelled <= cancelled_nxt;
`endif
    end
  end

endmodule
